lstm_gate_mac: RTL
==================

LSTM_GATE_MAC -- requirements
Module: lstm_gate_mac

Interface
REQ-001 SHALL expose parameter N_INPUTS, default 4, giving the number of weighted terms per result; legal range is 1..16.
REQ-002 SHALL expose parameter FRAC, default 4, giving the fractional bits of the Q3.4 data format; it SHALL match the downstream tanh stage.
REQ-003 clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  is the reset: synchronous, active-low.
REQ-005 start  input  1  is a one-cycle request to begin a new dot product; it is sampled only in IDLE.
REQ-006 bias  input  8  is a signed Q3.4 bias, captured on an accepted start.
REQ-007 x_valid  input  1  indicates that x_data and w_data hold a valid term.
REQ-008 x_data  input  8  is the signed Q3.4 input sample.
REQ-009 w_data  input  8  is the signed Q3.4 weight.
REQ-010 x_ready  output  1  is high only in ACC; a term is accepted when x_valid and x_ready are both high.
REQ-011 z_value  output  8  is the signed Q3.4 saturated pre-activation, fed to the tanh stage's z_value.
REQ-012 z_valid  output  1  indicates that z_value is valid.
REQ-013 z_ready  input  1  is the downstream acceptance signal.
REQ-014 busy  output  1  is high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, SCALE and OUT.
REQ-016 IDLE -> ACC on start; acc SHALL load sign-extended bias<<FRAC and cnt SHALL load 0.
REQ-017 In ACC, each accepted term SHALL add the full 16-bit signed product x_data*w_data into a 20-bit signed accumulator and increment cnt.
REQ-018 Cycles in ACC without x_valid SHALL hold acc and cnt unchanged, with no timeout.
REQ-019 ACC -> SCALE on the cycle the term with cnt==N_INPUTS-1 is accepted.
REQ-020 SCALE SHALL arithmetic-shift acc right by FRAC (floor toward minus infinity) and saturate to [-128,127], registering the result into z_value; SCALE -> OUT unconditionally.
REQ-021 OUT SHALL hold z_valid=1 with z_value stable until z_ready=1; on that cycle the block goes OUT -> IDLE and z_valid falls on the next cycle.
REQ-022 Latency SHALL be: z_valid rises exactly 2 cycles after the clock edge that accepts the last term.
REQ-023 start SHALL be ignored while busy=1, with no queuing.
REQ-024 In the IDLE cycle after an OUT handshake, start SHALL be accepted, giving one bubble cycle between results.
REQ-025 z_value SHALL keep its last result after the handshake until the next SCALE.
REQ-026 The accumulator SHALL NOT overflow for any inputs with N_INPUTS<=16; the bound is 16*16384+2048 < 2^19.
REQ-027 x_data and w_data SHALL be ignored whenever x_ready=0.

Reset
REQ-028 While rst=0 at a clock edge, the next state SHALL be: state=IDLE, acc=0, cnt=0, z_value=0, z_valid=0, x_ready=0, busy=0.
REQ-029 Reset asserted mid-operation, in any state, SHALL abort the computation and discard partial results.
REQ-030 The first start SHALL be accepted in the first cycle with rst=1.

Verification
REQ-031 The bench SHALL cover: N=4, bias=0, four terms x=16, w=16 -> z_value=64, with z_valid 2 cycles after the 4th accept.
REQ-032 The bench SHALL cover: bias=-16, four terms x=-16, w=16 -> acc=-1280 -> z_value=-80.
REQ-033 The bench SHALL cover saturation and floor: four terms x=127, w=127 -> z_value=127; four terms x=-128, w=127 -> z_value=-128; four terms x=-1, w=1 -> z_value=-1; four terms x=1, w=1 -> z_value=0.
REQ-034 The bench SHALL cover stalls and backpressure: x_valid toggled randomly with z_ready held low for 5 cycles -> result unchanged, z_value stable and z_valid held; start pulsed during ACC is ignored.
REQ-035 The bench SHALL cover reset mid-ACC after 2 terms -> all outputs 0; a new start with N fresh terms produces a correct result with no residue from the aborted run.
REQ-036 The bench SHALL cover back-to-back operation: start in the IDLE cycle right after a handshake -> accepted, with x_ready high on the following cycle.

Source files
------------

// File: rtl/lstm_gate_mac_if.sv
// Purpose : handshake/data bundle between the upstream term source and lstm_gate_mac.
// Latency : n/a (wires only).
// Backpr. : x_valid/x_ready for terms, z_valid/z_ready for results.
// Ports   : start/bias request, x_valid/x_data/w_data/x_ready term channel,
//           z_value/z_valid/z_ready result channel, busy status.
interface lstm_gate_mac_if;
  logic       start;
  logic [7:0] bias;
  logic       x_valid;
  logic [7:0] x_data;
  logic [7:0] w_data;
  logic       x_ready;
  logic [7:0] z_value;
  logic       z_valid;
  logic       z_ready;
  logic       busy;

  // master drives requests and terms and accepts results
  modport master (
    output start, bias, x_valid, x_data, w_data, z_ready,
    input  x_ready, z_value, z_valid, busy
  );

  // slave is the MAC itself
  modport slave (
    input  start, bias, x_valid, x_data, w_data, z_ready,
    output x_ready, z_value, z_valid, busy
  );
endinterface

// File: rtl/lstm_gate_mac.sv
// Purpose : LSTM gate pre-activation, z = sat8((bias<<FRAC + sum x*w) >>> FRAC), Q3.4 in/out.
// Latency : z_valid rises on the 2nd edge counting the edge that accepts the last term.
// Backpr. : terms stall freely via x_valid; the result is held in OUT until z_ready.
// Ports   : clk, rst (sync active-low), bus (lstm_gate_mac_if.slave: start/bias,
//           x_valid/x_data/w_data/x_ready, z_value/z_valid/z_ready, busy).
module lstm_gate_mac #(
  parameter int N_INPUTS = 4,
  parameter int FRAC     = 4
) (
  input  logic           clk,
  input  logic           rst,
  lstm_gate_mac_if.slave bus
);

  localparam int ACC_W = 20;
  localparam int CNT_W = 5;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 20'sd127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -20'sd128;

  typedef enum logic [1:0] {IDLE, ACC, SCALE, OUT} state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [7:0]              z_value_q;
  logic                    z_valid_q;
  logic                    x_ready_q;
  logic                    busy_q;

  logic signed [15:0]      prod_d;
  logic signed [ACC_W-1:0] acc_sum_d;
  logic signed [ACC_W-1:0] bias_ext_d;
  logic signed [ACC_W-1:0] acc_shr_d;
  logic [7:0]              z_sat_d;
  logic                    term_acc_d;
  logic                    last_term_d;

  always_comb begin
    prod_d      = $signed(bus.x_data) * $signed(bus.w_data);
    acc_sum_d   = acc_q + $signed({{(ACC_W-16){prod_d[15]}}, prod_d});
    // bias is Q3.4; shifting by FRAC aligns it with the Q6.8 products
    bias_ext_d  = $signed({{(ACC_W-8){bus.bias[7]}}, bus.bias}) <<< FRAC;
    // arithmetic shift floors toward minus infinity
    acc_shr_d   = acc_q >>> FRAC;
    if (acc_shr_d > SAT_MAX) begin
      z_sat_d = 8'h7f;
    end else if (acc_shr_d < SAT_MIN) begin
      z_sat_d = 8'h80;
    end else begin
      z_sat_d = acc_shr_d[7:0];
    end
    term_acc_d  = (state_q == ACC) && bus.x_valid && x_ready_q;
    last_term_d = term_acc_d && (cnt_q == CNT_W'(N_INPUTS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      z_value_q <= '0;
      z_valid_q <= 1'b0;
      x_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= ACC;
            acc_q     <= bias_ext_d;
            cnt_q     <= '0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ACC: begin
          if (term_acc_d) begin
            acc_q <= acc_sum_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_term_d) begin
              state_q   <= SCALE;
              x_ready_q <= 1'b0;
            end
          end
        end
        SCALE: begin
          z_value_q <= z_sat_d;
          z_valid_q <= 1'b1;
          state_q   <= OUT;
        end
        OUT: begin
          // z_value_q is left alone so the last result stays readable in IDLE
          if (bus.z_ready) begin
            z_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          x_ready_q <= 1'b0;
          z_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_ready = x_ready_q;
  assign bus.z_value = z_value_q;
  assign bus.z_valid = z_valid_q;
  assign bus.busy    = busy_q;

endmodule
